// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the IF/MEM byte-port arbiter: state encoding,
// access-width codes and the byte-lane / load-extension functions.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEFAULT = 17;

  localparam logic [1:0] MEM_WIDTH_BYTE = 2'b00;
  localparam logic [1:0] MEM_WIDTH_HALF = 2'b01;
  localparam logic [1:0] MEM_WIDTH_WORD = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_XFER = 2'd1,
    ARB_TAIL = 2'd2,
    ARB_DONE = 2'd3
  } arb_state_e;

  // Number of byte beats for an access width; the reserved code 11 is a word.
  function automatic logic [2:0] width_len(input logic [1:0] width);
    logic [2:0] len;
    case (width)
      MEM_WIDTH_BYTE: len = 3'd1;
      MEM_WIDTH_HALF: len = 3'd2;
      default:        len = 3'd4;
    endcase
    return len;
  endfunction

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  function automatic logic [31:0] set_lane(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

  // Narrow loads are zero- or sign-extended; word loads pass through.
  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] width,
                                              input logic sext);
    logic [31:0] r;
    case (width)
      MEM_WIDTH_BYTE: r = sext ? {{24{w[7]}}, w[7:0]} : {24'h000000, w[7:0]};
      MEM_WIDTH_HALF: r = sext ? {{16{w[15]}}, w[15:0]} : {16'h0000, w[15:0]};
      default:        r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single byte-wide RAM port between instruction fetch and the
// data stage, serialising 8/16/32-bit accesses into little-endian byte beats.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_width,
  input  logic              mem_sext,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic              stallreq_if,
  output logic              stallreq_mem,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  arb_state_e        state_r, state_s;
  logic              grant_mem_s, start_s, last_s;
  logic [1:0]        cnt_nxt_s;
  logic [31:0]       final_s;
  logic              grant_mem_r, prev_mem_r, we_r, sext_r;
  logic [1:0]        width_r, cnt_r;
  logic [2:0]        len_r;
  logic [ADDR_W-1:0] base_r;
  logic [31:0]       wdata_r, buf_r;
  logic              unused_s;

  // Only the low ADDR_W address bits reach the RAM.
  assign unused_s = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};

  assign stallreq_if  = if_req && !if_done;
  assign stallreq_mem = mem_req && !mem_done;

  // Arbitration decision, beat bookkeeping and next-state logic
  always_comb begin
    grant_mem_s = mem_req && (!if_req || !prev_mem_r);
    start_s     = mem_req || if_req;
    last_s      = ({1'b0, cnt_r} == (len_r - 3'd1));
    cnt_nxt_s   = cnt_r + 2'd1;
    final_s     = set_lane(buf_r, cnt_r, ram_din);
    state_s     = state_r;
    case (state_r)
      ARB_IDLE: begin
        if (start_s) state_s = ARB_XFER;
        else         state_s = ARB_IDLE;
      end
      ARB_XFER: begin
        if (last_s) begin
          if (we_r) state_s = ARB_DONE;
          else      state_s = ARB_TAIL;
        end else begin
          state_s = ARB_XFER;
        end
      end
      ARB_TAIL: state_s = ARB_DONE;
      ARB_DONE: state_s = ARB_IDLE;
      default:  state_s = ARB_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_r <= ARB_IDLE;
    else      state_r <= state_s;
  end

  // Request latch, RAM port drive, read-lane capture and done pulses
  always_ff @(posedge clk) begin
    if (!rst) begin
      grant_mem_r <= 1'b0;
      prev_mem_r  <= 1'b0;
      we_r        <= 1'b0;
      sext_r      <= 1'b0;
      width_r     <= MEM_WIDTH_WORD;
      len_r       <= 3'd4;
      cnt_r       <= 2'd0;
      base_r      <= '0;
      wdata_r     <= 32'h00000000;
      buf_r       <= 32'h00000000;
      ram_addr    <= '0;
      ram_wr      <= 1'b0;
      ram_dout    <= 8'h00;
      if_rdata    <= 32'h00000000;
      mem_rdata   <= 32'h00000000;
      if_done     <= 1'b0;
      mem_done    <= 1'b0;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (start_s) begin
            grant_mem_r <= grant_mem_s;
            prev_mem_r  <= grant_mem_s;
            cnt_r       <= 2'd0;
            buf_r       <= 32'h00000000;
            if (grant_mem_s) begin
              we_r     <= mem_we;
              sext_r   <= mem_sext;
              width_r  <= mem_width;
              len_r    <= width_len(mem_width);
              base_r   <= mem_addr[ADDR_W-1:0];
              wdata_r  <= mem_wdata;
              ram_addr <= mem_addr[ADDR_W-1:0];
              ram_wr   <= mem_we;
              ram_dout <= mem_wdata[7:0];
            end else begin
              we_r     <= 1'b0;
              sext_r   <= 1'b0;
              width_r  <= MEM_WIDTH_WORD;
              len_r    <= 3'd4;
              base_r   <= if_addr[ADDR_W-1:0];
              wdata_r  <= 32'h00000000;
              ram_addr <= if_addr[ADDR_W-1:0];
              ram_wr   <= 1'b0;
              ram_dout <= 8'h00;
            end
          end else begin
            ram_wr <= 1'b0;
          end
        end
        ARB_XFER: begin
          // ram_din now carries the byte addressed one beat earlier.
          if (!we_r && (cnt_r != 2'd0)) buf_r <= set_lane(buf_r, cnt_r - 2'd1, ram_din);
          if (last_s) begin
            ram_wr <= 1'b0;
            if (we_r) begin
              mem_done  <= 1'b1;
              mem_rdata <= 32'h00000000;
            end else begin
              mem_done <= 1'b0;
            end
          end else begin
            cnt_r    <= cnt_nxt_s;
            ram_addr <= base_r + ADDR_W'(cnt_nxt_s);
            ram_dout <= word_byte(wdata_r, cnt_nxt_s);
          end
        end
        ARB_TAIL: begin
          if (grant_mem_r) begin
            mem_done  <= 1'b1;
            mem_rdata <= load_extend(final_s, width_r, sext_r);
          end else begin
            if_done  <= 1'b1;
            if_rdata <= final_s;
          end
        end
        ARB_DONE: begin
          if_done   <= 1'b0;
          mem_done  <= 1'b0;
          if_rdata  <= 32'h00000000;
          mem_rdata <= 32'h00000000;
        end
        default: begin
          ram_wr   <= 1'b0;
          if_done  <= 1'b0;
          mem_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model predicts every
// cycle of RAM traffic and done pulses; literal checks pin the model.
module tb_mem_arbiter;

  localparam int AW   = 17;
  localparam int MASK = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, mem_req, mem_we, mem_sext;
  logic [31:0]   if_addr, mem_addr, mem_wdata;
  logic [1:0]    mem_width;
  logic [31:0]   if_rdata, mem_rdata;
  logic          if_done, mem_done, stallreq_if, stallreq_mem;
  logic [AW-1:0] ram_addr;
  logic          ram_wr;
  logic [7:0]    ram_dout, ram_din;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic [7:0] ram [0:MASK];
  logic [7:0] img [0:MASK];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_width(mem_width), .mem_sext(mem_sext),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Byte RAM: synchronous write, read data one cycle after the address
  always @(posedge clk) begin
    if (ram_wr) ram[ram_addr] <= ram_dout;
    ram_din <= ram[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Transaction-level reference model, compared every cycle on the falling edge
  initial begin : model
    bit          busy, t_mem, t_we, t_sext, prev_mem, rst_low_prev, g_done, g_mem;
    int          t_start, t_end, t_n, t_d, t_addr, o;
    logic [31:0] t_wdata, t_exp;
    logic [7:0]  b;
    busy = 1'b0; prev_mem = 1'b0; rst_low_prev = 1'b0;
    t_start = 0; t_end = 0; t_n = 0; t_d = 0; t_addr = 0;
    t_mem = 1'b0; t_we = 1'b0; t_sext = 1'b0; t_wdata = 32'h0; t_exp = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_low_prev) begin
        busy = 1'b0; prev_mem = 1'b0;
        chk("rst ram_addr", 32'(ram_addr), 32'h0);
        chk("rst ram_wr", 32'(ram_wr), 32'h0);
        chk("rst ram_dout", 32'(ram_dout), 32'h0);
        chk("rst if_rdata", if_rdata, 32'h0);
        chk("rst mem_rdata", mem_rdata, 32'h0);
        chk("rst if_done", 32'(if_done), 32'h0);
        chk("rst mem_done", 32'(mem_done), 32'h0);
      end else if (busy && cyc > t_end) begin
        busy = 1'b0;
      end
      if (!busy && rst && (mem_req || if_req)) begin
        g_mem = mem_req && (!if_req || !prev_mem);
        prev_mem = g_mem; t_mem = g_mem;
        if (g_mem) begin
          t_we = mem_we; t_sext = mem_sext; t_addr = int'(mem_addr) & MASK; t_wdata = mem_wdata;
          t_n = (mem_width == 2'b00) ? 1 : (mem_width == 2'b01) ? 2 : 4;
        end else begin
          t_we = 1'b0; t_sext = 1'b0; t_addr = int'(if_addr) & MASK; t_wdata = 32'h0; t_n = 4;
        end
        t_d = t_we ? t_n + 1 : t_n + 2;
        t_start = cyc; t_end = cyc + t_d; busy = 1'b1;
        t_exp = 32'h0;
        for (int i = 0; i < t_n; i++) t_exp = t_exp | (32'(img[(t_addr + i) & MASK]) << (8 * i));
        if (t_sext && t_n == 1 && t_exp[7])  t_exp = t_exp | 32'hFFFFFF00;
        if (t_sext && t_n == 2 && t_exp[15]) t_exp = t_exp | 32'hFFFF0000;
      end
      g_done = 1'b0;
      if (busy) begin
        o = cyc - t_start;
        g_done = (o == t_d);
        chk("ram_wr", 32'(ram_wr), 32'(t_we && o >= 1 && o <= t_n));
        if (o >= 1 && o <= t_n) begin
          chk("ram_addr", 32'(ram_addr), 32'((t_addr + o - 1) & MASK));
          if (t_we) begin
            b = t_wdata[8*(o-1) +: 8];
            chk("ram_dout", 32'(ram_dout), 32'(b));
            img[(t_addr + o - 1) & MASK] = b;
          end
        end
        chk("if_done", 32'(if_done), 32'(!t_mem && g_done));
        chk("mem_done", 32'(mem_done), 32'(t_mem && g_done));
        if (t_mem) chk("if_rdata held", if_rdata, 32'h0);
        else       chk("mem_rdata held", mem_rdata, 32'h0);
        if (g_done && !t_we) begin
          if (t_mem) chk("mem_rdata", mem_rdata, t_exp);
          else       chk("if_rdata", if_rdata, t_exp);
        end
      end else begin
        chk("idle ram_wr", 32'(ram_wr), 32'h0);
        chk("idle if_done", 32'(if_done), 32'h0);
        chk("idle mem_done", 32'(mem_done), 32'h0);
      end
      chk("stallreq_if", 32'(stallreq_if), 32'(if_req && !(busy && !t_mem && g_done)));
      chk("stallreq_mem", 32'(stallreq_mem), 32'(mem_req && !(busy && t_mem && g_done)));
      rst_low_prev = !rst;
    end
  end

  task automatic poke(input int a, input logic [7:0] v);
    ram[a] = v;
    img[a] = v;
  endtask

  task automatic run_op(input bit is_mem, input bit we, input logic [1:0] width, input bit sext,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output int lat);
    bit found;
    int t0;
    found = 1'b0; rd = 32'h0; lat = -1;
    @(posedge clk); #1;
    if (is_mem) begin
      mem_we = we; mem_width = width; mem_sext = sext; mem_addr = addr; mem_wdata = wdata;
      mem_req = 1'b1;
    end else begin
      if_addr = addr; if_req = 1'b1;
    end
    t0 = cyc;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (is_mem ? mem_done : if_done) begin
        found = 1'b1; rd = is_mem ? mem_rdata : if_rdata; lat = cyc - t0;
        break;
      end
    end
    chk("done timeout", 32'(found), 32'h1);
    @(posedge clk); #1;
    mem_req = 1'b0; if_req = 1'b0;
  endtask

  initial begin : stim
    logic [31:0] rd, rd_m, rd_i;
    int          lat, lat_m, lat_i, t0, stall_gaps;
    rst = 1'b0; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_sext = 1'b0;
    mem_width = 2'b00; if_addr = 32'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
    for (int i = 0; i <= MASK; i++) begin ram[i] = 8'h00; img[i] = 8'h00; end
    poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h10); poke(32'h103, 8'h00);
    poke(32'h20, 8'h80);  poke(32'h43, 8'h5A);
    poke(32'h1FFFF, 8'h11); poke(32'h0, 8'h22); poke(32'h1, 8'h33); poke(32'h2, 8'h44);
    poke(32'h202, 8'hC3); poke(32'h203, 8'h3C);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    run_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd, lat);
    chk("fetch data", rd, 32'h00100513);
    chk("fetch latency", 32'(lat), 32'd6);

    run_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h20, 32'h0, rd, lat);
    chk("lb sext", rd, 32'hFFFFFF80);
    chk("lb latency", 32'(lat), 32'd3);
    run_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0, rd, lat);
    chk("lbu", rd, 32'h00000080);

    run_op(1'b1, 1'b1, 2'b01, 1'b0, 32'h41, 32'hDEADBEEF, rd, lat);
    chk("sh latency", 32'(lat), 32'd3);
    chk("sh byte0", 32'(ram[32'h41]), 32'hEF);
    chk("sh byte1", 32'(ram[32'h42]), 32'hBE);
    chk("sh untouched", 32'(ram[32'h43]), 32'h5A);

    run_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h41, 32'h0, rd, lat);
    chk("lh sext", rd, 32'hFFFFBEEF);
    chk("lh latency", 32'(lat), 32'd4);

    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h1FFFF, 32'h0, rd, lat);
    chk("wrap word", rd, 32'h44332211);
    run_op(1'b1, 1'b0, 2'b11, 1'b1, 32'h100, 32'h0, rd, lat);
    chk("width11 word", rd, 32'h00100513);
    chk("width11 latency", 32'(lat), 32'd6);

    // Fetch first so that mem holds priority going into the contention case
    run_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd, lat);
    @(posedge clk); #1;
    mem_we = 1'b0; mem_width = 2'b00; mem_sext = 1'b0; mem_addr = 32'h20; if_addr = 32'h100;
    mem_req = 1'b1; if_req = 1'b1;
    t0 = cyc; lat_m = -1; lat_i = -1; rd_m = 32'h0; rd_i = 32'h0; stall_gaps = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!if_done && !stallreq_if) stall_gaps++;
      if (mem_done && lat_m < 0) begin lat_m = cyc - t0; rd_m = mem_rdata; end
      if (if_done) begin lat_i = cyc - t0; rd_i = if_rdata; break; end
    end
    @(posedge clk); #1;
    mem_req = 1'b0; if_req = 1'b0;
    chk("contend mem latency", 32'(lat_m), 32'd3);
    chk("contend mem data", rd_m, 32'h00000080);
    chk("contend if latency", 32'(lat_i), 32'd10);
    chk("contend if data", rd_i, 32'h00100513);
    chk("contend stall gaps", 32'(stall_gaps), 32'd0);

    // Reset lands at the end of cycle 2 of a word store
    @(posedge clk); #1;
    mem_we = 1'b1; mem_width = 2'b10; mem_sext = 1'b0; mem_addr = 32'h200; mem_wdata = 32'h11223344;
    mem_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; mem_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort ram_wr", 32'(ram_wr), 32'h0);
      chk("abort mem_done", 32'(mem_done), 32'h0);
    end
    chk("abort byte0", 32'(ram[32'h200]), 32'h44);
    chk("abort byte1", 32'(ram[32'h201]), 32'h33);
    chk("abort byte2", 32'(ram[32'h202]), 32'hC3);
    chk("abort byte3", 32'(ram[32'h203]), 32'h3C);
    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, rd, lat);
    chk("post-reset load", rd, 32'h3CC33344);
    chk("post-reset latency", 32'(lat), 32'd6);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
